msg_arbiter: RTL and testbench
==============================

MSG_ARBITER -- requirements
Module: msg_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 500, max cycles in WAIT for tx_done (5 s at 100 Hz).
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: nRst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: host_req  input  1  host send request, level, held until host_ack.
REQ-005 SHALL have port: host_data  input  8  host ASCII letter, stable while host_req high.
REQ-006 SHALL have port: host_ack  output  1  one-cycle pulse, host message sent.
REQ-007 SHALL have port: play_req  input  1  player send request, level, held until play_ack.
REQ-008 SHALL have port: play_data  input  8  player ASCII letter, stable while play_req high.
REQ-009 SHALL have port: play_ack  output  1  one-cycle pulse, player message sent.
REQ-010 SHALL have port: tx_start  output  1  one-cycle start strobe to shared transmitter.
REQ-011 SHALL have port: tx_data  output  8  registered byte to transmitter.
REQ-012 SHALL have port: tx_busy  input  1  transmitter cannot accept start.
REQ-013 SHALL have port: tx_done  input  1  one-cycle transmitter completion pulse.
REQ-014 SHALL have port: msg_sent  output  1  one-cycle pulse, any message completed.
REQ-015 SHALL have port: error  output  1  one-cycle pulse, transmit timeout.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT, DONE.
REQ-017 SHALL sample requests only in IDLE; any req high -> START next cycle, winner's data latched into tx_data on that edge.
REQ-018 SHALL arbitrate round-robin on simultaneous requests: grant the requester not served last; last_grant updates only on DONE.
REQ-019 SHALL grant a lone requester regardless of last_grant.
REQ-020 SHALL in START assert tx_start combinationally equal to !tx_busy; START -> WAIT on the cycle tx_start is high; stall in START while tx_busy.
REQ-021 SHALL hold tx_start high for exactly one cycle per grant.
REQ-022 SHALL in WAIT count cycles from 0; tx_done=1 -> DONE; count reaching TIMEOUT_CYCLES-1 without tx_done -> IDLE with error pulse, no ack, last_grant unchanged (same requester retried).
REQ-023 SHALL treat tx_done and timeout in the same cycle as success (DONE).
REQ-024 SHALL in DONE pulse the granted ack and msg_sent for one cycle, then -> IDLE.
REQ-025 SHALL ignore tx_done outside WAIT.
REQ-026 SHALL give minimum latency IDLE-req to tx_start of 1 cycle; tx_done to ack of 1 cycle.
REQ-027 SHALL keep tx_data stable from START until the next grant.
REQ-028 SHALL size the timeout counter as $clog2(TIMEOUT_CYCLES+1) bits, no wrap.

Reset
REQ-029 SHALL on nRst=0 immediately force state IDLE, tx_data 8'h00, counter 0, last_grant=player (so host wins first tie).
REQ-030 SHALL drive all outputs 0 during reset; reset mid-WAIT abandons the message with no ack and no error.

Structure
REQ-031 SHALL place the state enum msg_arb_state_t and requester enum (HOST, PLAYER) in the shared hangman_pkg package.
REQ-032 SHALL implement the timeout counter as one sub-module, msg_timer (enable, clear, expired).

Verification
REQ-033 SHALL cover: host_req=1, host_data=8'h41, tx_done 3 cycles after tx_start -> tx_start 1 cycle with tx_data=8'h41, host_ack+msg_sent 1 cycle after tx_done.
REQ-034 SHALL cover: host_req and play_req both high from reset, data 8'h41/8'h50 -> host served first, then player; tx_data sequence 41,50.
REQ-035 SHALL cover: tx_busy=1 for 10 cycles at grant -> tx_start delayed exactly until tx_busy falls, still single pulse.
REQ-036 SHALL cover: TIMEOUT_CYCLES=8, no tx_done -> error 1-cycle pulse, no ack, same requester re-granted.
REQ-037 SHALL cover: nRst low in WAIT -> outputs 0 at once, no ack/error; after release, pending host_req re-served.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared types for the hangman message path: arbiter FSM states and requester identities.
package hangman_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDone
  } msg_arb_state_t;

  typedef enum logic {
    Host   = 1'b0,
    Player = 1'b1
  } requester_t;

  localparam logic [7:0] TxDataRst = 8'h00;

endpackage

// File: rtl/msg_timer.sv
// Saturating cycle counter for the transmit timeout; expired_o flags the final allowed cycle.
module msg_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500
) (
  input  logic clk,
  input  logic nRst,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at the last value (never wraps).
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/msg_arbiter.sv
// Round-robin arbiter sharing one byte transmitter between the host and the player.
module msg_arbiter
  import hangman_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       host_req,
  input  logic [7:0] host_data,
  output logic       host_ack,
  input  logic       play_req,
  input  logic [7:0] play_data,
  output logic       play_ack,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       msg_sent,
  output logic       error
);

  msg_arb_state_t state_q, state_d;
  requester_t     grant_q, grant_d;
  requester_t     last_grant_q, last_grant_d;
  requester_t     winner;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           timer_expired;

  msg_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_msg_timer (
    .clk      (clk),
    .nRst     (nRst),
    .enable_i (state_q == StWait),
    .clear_i  (state_q != StWait),
    .expired_o(timer_expired)
  );

  // Pick the winner: a lone requester always wins, a tie goes to whoever was not served last.
  always_comb begin
    winner = Host;
    if (host_req && play_req) begin
      winner = (last_grant_q == Host) ? Player : Host;
    end else if (play_req) begin
      winner = Player;
    end
  end

  // FSM next-state and strobes.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_data_d    = tx_data_q;
    tx_start     = 1'b0;
    host_ack     = 1'b0;
    play_ack     = 1'b0;
    msg_sent     = 1'b0;
    error        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (host_req || play_req) begin
          grant_d   = winner;
          tx_data_d = (winner == Host) ? host_data : play_data;
          state_d   = StStart;
        end
      end
      StStart: begin
        tx_start = !tx_busy;
        if (!tx_busy) begin
          state_d = StWait;
        end
      end
      StWait: begin
        // A completion in the timeout cycle still counts as success.
        if (tx_done) begin
          state_d = StDone;
        end else if (timer_expired) begin
          // last_grant untouched so a tie retries the same requester.
          error   = 1'b1;
          state_d = StIdle;
        end
      end
      StDone: begin
        msg_sent     = 1'b1;
        host_ack     = (grant_q == Host);
        play_ack     = (grant_q == Player);
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; last_grant resets to Player so the host wins the first tie.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= StIdle;
      grant_q      <= Host;
      last_grant_q <= Player;
      tx_data_q    <= TxDataRst;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_msg_arbiter.sv
// Directed bench for msg_arbiter; inputs change on the falling edge, outputs sampled there too.
module tb_msg_arbiter;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       host_req = 1'b0;
  logic [7:0] host_data = 8'h00;
  logic       host_ack;
  logic       play_req = 1'b0;
  logic [7:0] play_data = 8'h00;
  logic       play_ack;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic       msg_sent;
  logic       error;

  int checks = 0;
  int errors = 0;

  msg_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .host_req (host_req),
    .host_data(host_data),
    .host_ack (host_ack),
    .play_req (play_req),
    .play_data(play_data),
    .play_ack (play_ack),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .msg_sent (msg_sent),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_host_ack: got %b expected 0", host_ack); end
    checks++; if (play_ack !== 1'b0) begin errors++; $display("FAIL reset_play_ack: got %b expected 0", play_ack); end
    checks++; if (msg_sent !== 1'b0) begin errors++; $display("FAIL reset_msg_sent: got %b expected 0", msg_sent); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    nRst = 1'b1;
  endtask

  task automatic test_single_host();
    @(negedge clk);
    host_req = 1'b1; host_data = 8'h41;
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", tx_start); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", tx_data); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b expected 0", tx_start); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL single_early_ack: got %b expected 0", host_ack); end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL single_host_ack: got %b expected 1", host_ack); end
    checks++; if (msg_sent !== 1'b1) begin errors++; $display("FAIL single_msg_sent: got %b expected 1", msg_sent); end
    checks++; if (play_ack !== 1'b0) begin errors++; $display("FAIL single_play_ack: got %b expected 0", play_ack); end
    host_req = 1'b0;
    @(negedge clk);
    checks++; if ({host_ack, msg_sent} !== 2'b00) begin errors++; $display("FAIL single_ack_pulse: got %b expected 00", {host_ack, msg_sent}); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data_hold: got %h expected 41", tx_data); end
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    nRst = 1'b0;
    host_req = 1'b1; play_req = 1'b1; host_data = 8'h41; play_data = 8'h50;
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL rr_start1: got %b expected 1", tx_start); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL rr_data1: got %h expected 41", tx_data); end
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++; if ({host_ack, play_ack} !== 2'b10) begin errors++; $display("FAIL rr_ack1: got %b expected 10", {host_ack, play_ack}); end
    host_data = 8'h42;
    @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rr_idle_gap: got %b expected 0", tx_start); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL rr_start2: got %b expected 1", tx_start); end
    checks++; if (tx_data !== 8'h50) begin errors++; $display("FAIL rr_data2: got %h expected 50", tx_data); end
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++; if ({host_ack, play_ack} !== 2'b01) begin errors++; $display("FAIL rr_ack2: got %b expected 01", {host_ack, play_ack}); end
    checks++; if (msg_sent !== 1'b1) begin errors++; $display("FAIL rr_msg_sent2: got %b expected 1", msg_sent); end
    play_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (tx_data !== 8'h42) begin errors++; $display("FAIL rr_data3: got %h expected 42", tx_data); end
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++; if ({host_ack, play_ack} !== 2'b10) begin errors++; $display("FAIL rr_ack3: got %b expected 10", {host_ack, play_ack}); end
    host_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_busy_stall();
    @(negedge clk);
    host_req = 1'b1; host_data = 8'h43; tx_busy = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL busy_stall_%0d: got %b expected 0", i, tx_start); end
      // A stray completion while stalled in START must be ignored.
      tx_done = (i == 3);
    end
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL busy_stray_done: got %b expected 0", host_ack); end
    tx_busy = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL busy_release: got %b expected 1", tx_start); end
    checks++; if (tx_data !== 8'h43) begin errors++; $display("FAIL busy_data: got %h expected 43", tx_data); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL busy_pulse: got %b expected 0", tx_start); end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL busy_ack: got %b expected 1", host_ack); end
    host_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    // Host was served last, so the tie goes to the player.
    @(negedge clk);
    host_req = 1'b1; play_req = 1'b1; host_data = 8'h44; play_data = 8'h51;
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL to_start1: got %b expected 1", tx_start); end
    checks++; if (tx_data !== 8'h51) begin errors++; $display("FAIL to_data1: got %h expected 51", tx_data); end
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_early_%0d: got %b expected 0", i, error); end
    end
    @(negedge clk);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error: got %b expected 1", error); end
    checks++; if ({host_ack, play_ack, msg_sent} !== 3'b000) begin errors++; $display("FAIL to_no_ack: got %b expected 000", {host_ack, play_ack, msg_sent}); end
    @(negedge clk);
    checks++; if ({error, tx_start} !== 2'b00) begin errors++; $display("FAIL to_error_pulse: got %b expected 00", {error, tx_start}); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL to_retry_start: got %b expected 1", tx_start); end
    checks++; if (tx_data !== 8'h51) begin errors++; $display("FAIL to_retry_data: got %h expected 51", tx_data); end
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++; if ({host_ack, play_ack} !== 2'b01) begin errors++; $display("FAIL to_retry_ack: got %b expected 01", {host_ack, play_ack}); end
    host_req = 1'b0; play_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_done_at_timeout();
    @(negedge clk);
    host_req = 1'b1; host_data = 8'h46;
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL tie_start: got %b expected 1", tx_start); end
    repeat (8) @(negedge clk);
    tx_done = 1'b1;
    #1;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL tie_no_error: got %b expected 0", error); end
    @(negedge clk);
    tx_done = 1'b0;
    checks++; if ({host_ack, msg_sent, error} !== 3'b110) begin errors++; $display("FAIL tie_ack: got %b expected 110", {host_ack, msg_sent, error}); end
    host_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    host_req = 1'b1; host_data = 8'h45;
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL rst_start: got %b expected 1", tx_start); end
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b0;
    #1;
    checks++; if ({tx_start, host_ack, play_ack, msg_sent, error} !== 5'b00000) begin errors++; $display("FAIL rst_outputs: got %b expected 00000", {tx_start, host_ack, play_ack, msg_sent, error}); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    @(negedge clk);
    checks++; if ({host_ack, error} !== 2'b00) begin errors++; $display("FAIL rst_hold: got %b expected 00", {host_ack, error}); end
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL rst_reserve_start: got %b expected 1", tx_start); end
    checks++; if (tx_data !== 8'h45) begin errors++; $display("FAIL rst_reserve_data: got %h expected 45", tx_data); end
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL rst_reserve_ack: got %b expected 1", host_ack); end
    host_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_host();
    test_round_robin();
    test_busy_stall();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
